// File: rtl/mod_mul_scheduler.sv
// Round-robin scheduler that shares one external modular multiplier among NUM_REQ requesters.
// Operand width comes from `DATAWIDTH (parameters.vh); it falls back to 16 bits when the macro is undefined.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module mod_mul_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024,
   parameter int W       = `DATAWIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*W-1:0] op_a,
   input  logic [NUM_REQ*W-1:0] op_b,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic [W-1:0]         result,
   output logic                 err,
   output logic                 mul_en,
   output logic [W-1:0]         mul_a,
   output logic [W-1:0]         mul_b,
   input  logic [W-1:0]         mul_product,
   input  logic                 mul_ready
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, ACK, WAIT, DELIVER} state_t;

   state_t          state;
   state_t          state_next;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;
   logic            found;
   logic [CW-1:0]   cnt;
   logic            grant_now;
   logic            complete;
   logic            timeout_hit;
   logic [NUM_REQ-1:0] sel_onehot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Round-robin pick scans from ptr so the most recently served requester goes last.
   always_comb begin
      state_next  = state;
      pick        = '0;
      cand        = '0;
      found       = 1'b0;
      grant_now   = 1'b0;
      complete    = 1'b0;
      timeout_hit = 1'b0;

      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end

      case (state)
         IDLE: begin
            if (found) begin
               grant_now  = 1'b1;
               state_next = LAUNCH;
            end
         end
         LAUNCH: state_next = ACK;
         ACK: begin
            if (cnt == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_next  = DELIVER;
            end else if (!mul_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (mul_ready) begin
               complete   = 1'b1;
               state_next = DELIVER;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_next  = DELIVER;
            end
         end
         DELIVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase

      sel_onehot = NUM_REQ'(1) << sel;
      gnt        = (state != IDLE) ? sel_onehot : '0;
      done       = (state == DELIVER) ? sel_onehot : '0;
      mul_en     = (state == LAUNCH) || (state == ACK);
   end

   // Operands are captured at grant so requesters may change their buses freely afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel    <= '0;
         ptr    <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         cnt    <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         if (grant_now) begin
            sel   <= pick;
            ptr   <= IW'((int'(pick) + 1) % NUM_REQ);
            mul_a <= op_a[pick*W +: W];
            mul_b <= op_b[pick*W +: W];
            cnt   <= '0;
         end else if ((state == ACK) || (state == WAIT)) begin
            cnt <= cnt + CW'(1);
         end

         if (complete) begin
            result <= mul_product;
         end else if (timeout_hit) begin
            result <= '0;
            err    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod_mul_scheduler.sv
// Self-checking bench for mod_mul_scheduler: a behavioural modular multiplier plus a
// round-robin reference model predict grant order, products, latency and the sticky error flag.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module tb_mod_mul_scheduler;

   localparam int     NUM_REQ = 4;
   localparam int     TO      = 16;
   localparam int     W       = `DATAWIDTH;
   localparam longint P       = (W >= 16) ? 65521 : 251;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*W-1:0] op_a;
   logic [NUM_REQ*W-1:0] op_b;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   done;
   logic [W-1:0]         result;
   logic                 err;
   logic                 mul_en;
   logic [W-1:0]         mul_a;
   logic [W-1:0]         mul_b;
   logic [W-1:0]         mul_product;
   logic                 mul_ready;

   int checks = 0;
   int errors = 0;
   int mult_lat = 2;
   bit hang = 1'b0;
   int ptr_m = 0;
   bit err_m = 1'b0;

   logic         en_q;
   logic         busy;
   int           lat_left;
   logic [W-1:0] pa;
   logic [W-1:0] pb;

   mod_mul_scheduler #(
      .NUM_REQ(NUM_REQ),
      .TIMEOUT(TO),
      .W(W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .op_a(op_a),
      .op_b(op_b),
      .gnt(gnt),
      .done(done),
      .result(result),
      .err(err),
      .mul_en(mul_en),
      .mul_a(mul_a),
      .mul_b(mul_b),
      .mul_product(mul_product),
      .mul_ready(mul_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: a rising mul_en starts an operation, ready drops, then rises after mult_lat cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_ready   <= 1'b1;
         mul_product <= '0;
         en_q        <= 1'b0;
         busy        <= 1'b0;
         lat_left    <= 0;
         pa          <= '0;
         pb          <= '0;
      end else begin
         en_q <= mul_en;
         if (mul_en && !en_q) begin
            mul_ready <= 1'b0;
            busy      <= 1'b1;
            lat_left  <= mult_lat;
            pa        <= mul_a;
            pb        <= mul_b;
         end else if (busy) begin
            if (lat_left == 0) begin
               busy <= 1'b0;
               if (!hang) begin
                  mul_ready   <= 1'b1;
                  mul_product <= W'((64'(pa) * 64'(pb)) % P);
               end
            end else begin
               lat_left <= lat_left - 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic apply_stimulus(input logic [NUM_REQ-1:0] r, input bit zero_ok);
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a[i*W +: W] = (zero_ok && ($urandom_range(0, 5) == 0)) ? '0 : W'($urandom);
         op_b[i*W +: W] = (zero_ok && ($urandom_range(0, 5) == 0)) ? '0 : W'($urandom);
      end
      req = r;
   endtask

   // Runs one full operation from IDLE with req already driven, checking it against the model.
   task automatic serve_one(input string tag, input bit hang_exp, input bit drop_req, input bit change_op);
      int           exp_idx;
      int           exp_ticks;
      int           waited;
      bit           stable;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic [W-1:0] exp_res;

      exp_idx   = rr_pick(req, ptr_m);
      ea        = op_a[exp_idx*W +: W];
      eb        = op_b[exp_idx*W +: W];
      exp_res   = hang_exp ? '0 : W'((64'(ea) * 64'(eb)) % P);
      exp_ticks = hang_exp ? TO + 1 : 3 + mult_lat;
      if (hang_exp) err_m = 1'b1;

      tick();
      check_output({tag, "_gnt"}, 64'(gnt), 64'(1) << exp_idx);
      check_output({tag, "_mul_en"}, 64'(mul_en), 64'(1));
      if (drop_req) req = '0;
      if (change_op) op_a[exp_idx*W +: W] = ~ea;

      stable = 1'b1;
      waited = 0;
      while (done == '0 && waited < 60) begin
         if (mul_a !== ea || mul_b !== eb) stable = 1'b0;
         tick();
         waited++;
      end

      check_output({tag, "_done"}, 64'(done), 64'(1) << exp_idx);
      check_output({tag, "_result"}, 64'(result), 64'(exp_res));
      check_output({tag, "_latency"}, 64'(waited), 64'(exp_ticks));
      check_output({tag, "_operands_held"}, 64'(stable), 64'(1));
      check_output({tag, "_err"}, 64'(err), 64'(err_m));
      ptr_m = (exp_idx + 1) % NUM_REQ;

      tick();
      check_output({tag, "_done_clear"}, 64'(done), 64'(0));
      check_output({tag, "_gnt_clear"}, 64'(gnt), 64'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      op_a  = '0;
      op_b  = '0;
      #2;
      check_output("rst_gnt", 64'(gnt), 64'(0));
      check_output("rst_done", 64'(done), 64'(0));
      check_output("rst_mul_en", 64'(mul_en), 64'(0));
      check_output("rst_result", 64'(result), 64'(0));
      check_output("rst_err", 64'(err), 64'(0));
      check_output("rst_mul_a", 64'(mul_a), 64'(0));
      check_output("rst_mul_b", 64'(mul_b), 64'(0));
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Single request with 3 * 5.
      mult_lat = 2;
      apply_stimulus(4'b0001, 1'b0);
      op_a[0 +: W] = W'(3);
      op_b[0 +: W] = W'(5);
      serve_one("single", 1'b0, 1'b0, 1'b0);
      req = '0;
      tick();

      // Pointer now sits at 1, so requester 3 goes before 0.
      apply_stimulus(4'b1001, 1'b0);
      serve_one("skip_a", 1'b0, 1'b0, 1'b0);
      serve_one("skip_b", 1'b0, 1'b0, 1'b0);

      // Full contention for eight operations.
      for (int n = 0; n < 8; n++) begin
         mult_lat = $urandom_range(0, 5);
         apply_stimulus(4'b1111, 1'b0);
         serve_one("contend", 1'b0, 1'b0, 1'b0);
      end

      // Random request mixes, zero operands and dropped requests.
      for (int n = 0; n < 20; n++) begin
         mult_lat = $urandom_range(0, 6);
         apply_stimulus(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 1'b1);
         serve_one("random", 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
      end

      // Operand bus changes right after grant.
      mult_lat = 3;
      apply_stimulus(4'b0110, 1'b0);
      serve_one("op_change", 1'b0, 1'b0, 1'b1);
      req = '0;
      tick();

      // Multiplier never completes.
      hang = 1'b1;
      apply_stimulus(4'b0100, 1'b0);
      serve_one("timeout", 1'b1, 1'b1, 1'b0);
      hang = 1'b0;
      mult_lat = 1;
      apply_stimulus(4'b1000, 1'b0);
      serve_one("after_to", 1'b0, 1'b1, 1'b0);
      tick();

      // Reset while the multiplier is still busy.
      mult_lat = 10;
      apply_stimulus(4'b0001, 1'b0);
      repeat (3) tick();
      check_output("pre_rst_wait_mul_en", 64'(mul_en), 64'(0));
      check_output("pre_rst_wait_gnt", 64'(gnt), 64'(1));
      rst_n = 1'b0;
      #1;
      check_output("async_gnt", 64'(gnt), 64'(0));
      check_output("async_done", 64'(done), 64'(0));
      check_output("async_err", 64'(err), 64'(0));
      check_output("async_mul_a", 64'(mul_a), 64'(0));
      check_output("async_mul_b", 64'(mul_b), 64'(0));
      check_output("async_result", 64'(result), 64'(0));
      req = '0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check_output("rst_hold_done", 64'(done), 64'(0));
      end
      rst_n = 1'b1;
      ptr_m = 0;
      err_m = 1'b0;
      tick();
      check_output("post_rst_idle_done", 64'(done), 64'(0));

      mult_lat = 2;
      apply_stimulus(4'b0010, 1'b0);
      serve_one("post_rst", 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b1110, 1'b0);
      serve_one("post_rst_rr", 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
